// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble, header with sequence number, buffered payload and FCS,
// sent one byte per clk125 cycle on a DDR nibble bus, followed by an inter-frame gap.
//
// state | meaning
// IDLE  | waiting for a frame request, buf_ready high
// PRE   | 7 x 0x55 then 0xD5
// HDR   | DST_MAC, SRC_MAC, ETYPE, seq low, seq high
// PAY   | PAYLOAD_LEN bytes from the payload buffer
// FCS   | ~CRC32, LSB first
// IFG   | idle gap; with the accept cycle in IDLE it spans IFG byte-times
module eth_tx_framer #(
  parameter int          PAYLOAD_LEN = 1024,
  parameter int          NBUF        = 2,
  parameter logic [47:0] DST_MAC     = 48'h222222222222,
  parameter logic [47:0] SRC_MAC     = 48'h666666666666,
  parameter logic [15:0] ETYPE       = 16'h1919,
  parameter int          IFG         = 12,
  parameter int          RD_LAT      = 1,
  localparam int         SW          = $clog2(NBUF)
) (
  input  logic           clk125,
  input  logic           rstn,
  input  logic           buf_valid,
  input  logic [SW-1:0]  buf_sel,
  output logic           buf_ready,
  output logic [SW+10:0] rd_addr,
  input  logic [7:0]     rd_data,
  output logic           txctl,
  output logic [3:0]     txd,
  output logic [15:0]    seq,
  output logic           frame_done,
  output logic           busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_FCS  = 3'd4;
  localparam logic [2:0] S_IFG  = 3'd5;

  localparam logic [10:0] LAST_PAY = 11'(PAYLOAD_LEN - 1);
  localparam logic [10:0] LAST_IFG = 11'(IFG - 2);
  localparam logic [10:0] RD_START = 11'(15 - RD_LAT);

  logic [2:0]    state, state_n;
  logic [10:0]   cnt, cnt_n;
  logic [7:0]    txbyte, byte_n;
  logic [SW-1:0] slot;
  logic [31:0]   crc, fcs;
  logic [127:0]  hdr;
  logic          rd_run, rd_start, last_fcs;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign hdr      = {DST_MAC, SRC_MAC, ETYPE, seq[7:0], seq[15:8]};
  assign fcs      = ~crc;
  assign last_fcs = (state == S_FCS) && (cnt == 11'd3);
  assign txd      = clk125 ? txbyte[3:0] : txbyte[7:4];

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 11'd1;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (buf_valid && buf_ready) state_n = S_PRE;
      end
      S_PRE: if (cnt == 11'd7)    begin state_n = S_HDR; cnt_n = '0; end
      S_HDR: if (cnt == 11'd15)   begin state_n = S_PAY; cnt_n = '0; end
      S_PAY: if (cnt == LAST_PAY) begin state_n = S_FCS; cnt_n = '0; end
      S_FCS: if (cnt == 11'd3)    begin state_n = S_IFG; cnt_n = '0; end
      S_IFG: if (cnt == LAST_IFG) begin state_n = S_IDLE; cnt_n = '0; end
      default: begin state_n = S_IDLE; cnt_n = '0; end
    endcase
  end

  // byte_n is what goes on the wire in the cycle after this edge
  always_comb begin
    byte_n = 8'h00;
    case (state_n)
      S_PRE:   byte_n = (cnt_n == 11'd7) ? 8'hD5 : 8'h55;
      S_HDR:   byte_n = hdr[8*(15 - int'(cnt_n[3:0])) +: 8];
      S_PAY:   byte_n = rd_data;
      S_FCS:   byte_n = fcs[8*int'(cnt_n[1:0]) +: 8];
      default: byte_n = 8'h00;
    endcase
  end

  // first payload address goes out RD_LAT+1 cycles before payload byte 0 is on the wire
  assign rd_start = (state_n == S_HDR) && (cnt_n == RD_START);

  always_ff @(posedge clk125) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      slot       <= '0;
      txctl      <= 1'b0;
      txbyte     <= 8'h00;
      seq        <= 16'h0000;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      buf_ready  <= 1'b0;
      rd_addr    <= '0;
      rd_run     <= 1'b0;
      crc        <= 32'hFFFFFFFF;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      txbyte     <= byte_n;
      txctl      <= state_n inside {S_PRE, S_HDR, S_PAY, S_FCS};
      busy       <= (state_n != S_IDLE);
      buf_ready  <= (state_n == S_IDLE);
      frame_done <= last_fcs;
      if (last_fcs) seq <= seq + 16'd1;

      if (state == S_IDLE && state_n == S_PRE) begin
        slot <= buf_sel;
        crc  <= 32'hFFFFFFFF;
      end else if (state_n == S_HDR || state_n == S_PAY) begin
        crc <= crc_byte(crc, byte_n);
      end

      if (rd_start) begin
        rd_addr <= {slot, 11'd0};
        rd_run  <= 1'b1;
      end else if (rd_run) begin
        if (rd_addr[10:0] == LAST_PAY) rd_run <= 1'b0;
        else rd_addr[10:0] <= rd_addr[10:0] + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: a frame-array/timeline model predicts every output each cycle,
// with literal pins on the first frame, gap length, truncation and slot selection.
module tb_eth_tx_framer;
  localparam int PL   = 46;
  localparam int NB   = 4;
  localparam int RDL  = 2;
  localparam int IFGP = 12;
  localparam int SW   = 2;
  localparam int AW   = SW + 11;
  localparam int L    = 28 + PL;
  localparam logic [47:0] DST = 48'h222222222222;
  localparam logic [47:0] SRC = 48'h666666666666;
  localparam logic [15:0] ET  = 16'h1919;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          buf_valid = 1'b0;
  logic [SW-1:0] buf_sel = '0;
  logic          buf_ready, txctl, frame_done, busy;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [3:0]    txd;
  logic [15:0]   seq;

  eth_tx_framer #(.PAYLOAD_LEN(PL), .NBUF(NB), .DST_MAC(DST), .SRC_MAC(SRC), .ETYPE(ET),
                  .IFG(IFGP), .RD_LAT(RDL)) dut (
    .clk125(clk), .rstn(rstn), .buf_valid(buf_valid), .buf_sel(buf_sel), .buf_ready(buf_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .txctl(txctl), .txd(txd), .seq(seq),
    .frame_done(frame_done), .busy(busy));

  always #4 clk = ~clk;

  // payload memory with RDL cycles of read latency
  logic [7:0] mem [0:NB*2048-1];
  logic [7:0] rd_pipe [0:RDL-1];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[rd_addr];
    for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign rd_data = rd_pipe[RDL-1];

  int n_checks = 0;
  int n_fail = 0;
  int fd_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [31:0] crc_tab [0:255];
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    return (c >> 8) ^ crc_tab[(c[7:0] ^ d)];
  endfunction

  // model: whole expected frame built at accept, then walked by position
  logic [7:0]    fr [0:L-1];
  logic [7:0]    cap [0:L-1];
  int            m_pos = -1;
  int            m_frames = 0;
  logic [SW-1:0] m_slot = '0;
  logic [15:0]   m_seq = 16'h0;
  logic          m_inrst = 1'b1;
  logic          e_ready = 1'b0, e_txctl = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [7:0]    e_byte = 8'h00;

  task automatic build_frame();
    logic [31:0] c;
    for (int i = 0; i < 7; i++) fr[i] = 8'h55;
    fr[7] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      fr[8+i]  = 8'(DST >> (40 - 8*i));
      fr[14+i] = 8'(SRC >> (40 - 8*i));
    end
    fr[20] = ET[15:8];
    fr[21] = ET[7:0];
    fr[22] = m_seq[7:0];
    fr[23] = m_seq[15:8];
    for (int j = 0; j < PL; j++) fr[24+j] = mem[int'(m_slot)*2048 + j];
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 24 + PL; i++) c = crc_upd(c, fr[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) fr[24+PL+k] = 8'(c >> (8*k));
  endtask

  initial forever begin
    @(posedge clk);
    if (!rstn) begin
      m_pos = -1; e_ready = 1'b0; m_seq = 16'h0; m_inrst = 1'b1;
    end else begin
      m_inrst = 1'b0;
      if (m_pos < 0) begin
        if (buf_valid && e_ready) begin
          m_slot = buf_sel; build_frame(); m_pos = 0; m_frames++;
        end
      end else begin
        if (m_pos == L - 1) m_seq = m_seq + 16'd1;
        m_pos = (m_pos == L + IFGP - 2) ? -1 : m_pos + 1;
      end
      e_ready = (m_pos < 0);
    end
    e_txctl = (m_pos >= 0 && m_pos < L);
    if (e_txctl) e_byte = fr[m_pos];
    else e_byte = 8'h00;
    e_busy = (m_pos >= 0);
    e_done = (m_pos == L);
  end

  initial begin
    logic [AW-1:0] prev_rd;
    prev_rd = '0;
    forever begin
      @(posedge clk); #1;
      chk("txctl", txctl, e_txctl);
      chk("txd_lo", txd, e_byte[3:0]);
      chk("busy", busy, e_busy);
      chk("frame_done", frame_done, e_done);
      chk("seq", seq, m_seq);
      chk("buf_ready", buf_ready, e_ready);
      if (m_inrst) chk("rd_addr_rst", rd_addr, 0);
      else if (m_pos >= 0 && rd_addr !== prev_rd) chk("rd_slot", rd_addr[AW-1:11], m_slot);
      prev_rd = rd_addr;
      if (frame_done === 1'b1) fd_count++;
      if (m_frames == 1 && m_pos >= 0 && m_pos < L) cap[m_pos][3:0] = txd;
      @(negedge clk); #1;
      chk("txd_hi", txd, e_byte[7:4]);
      if (m_frames == 1 && m_pos >= 0 && m_pos < L) cap[m_pos][7:4] = txd;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_txctl(input logic lvl, input int maxc, output int n);
    n = 0;
    while (txctl !== lvl && n < maxc) begin cyc(); n++; end
    chk("wait_txctl", txctl, lvl);
  endtask

  initial begin
    int n, fd0;
    int          pin_idx [8];
    logic [7:0]  pin_val [8];
    logic [31:0] c;
    string       s;
    pin_idx = '{0, 7, 8, 14, 20, 22, 24, 24 + 45};
    pin_val = '{8'h55, 8'hD5, 8'h22, 8'h66, 8'h19, 8'h00, 8'h00, 8'h2D};

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
    for (int a = 0; a < NB*2048; a++)
      mem[a] = (a < 2048) ? 8'(a) : 8'($urandom_range(0, 255));
    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crc_upd(c, s[i]);
    chk("crc_check_value", ~c, 32'hCBF43926);

    // reset with buf_valid asserted, then back-to-back frames
    buf_valid = 1'b1;
    repeat (3) cyc();
    chk("rst_txctl", txctl, 0);
    chk("rst_txd", txd, 0);
    chk("rst_seq", seq, 0);
    chk("rst_ready", buf_ready, 0);
    rstn = 1'b1;
    cyc();
    chk("rel_ready", buf_ready, 1);
    chk("rel_txctl", txctl, 0);
    cyc();
    chk("accept_txctl", txctl, 1);
    wait_txctl(1'b0, 200, n);
    chk("frame_len", n, L);
    wait_txctl(1'b1, 100, n);
    chk("ifg_gap0", n, IFGP);
    for (int i = 0; i < 8; i++) chk("frame0_pin", cap[pin_idx[i]], pin_val[i]);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < L; i++) c = crc_upd(c, cap[i]);
    chk("crc_residue", c, 32'hDEBB20E3);
    wait_txctl(1'b0, 200, n);
    wait_txctl(1'b1, 100, n);
    chk("ifg_gap1", n, IFGP);
    buf_valid = 1'b0;
    wait_txctl(1'b0, 200, n);
    repeat (20) cyc();
    chk("seq_after3", seq, 3);
    chk("done_count3", fd_count, 3);

    // slot latched at accept; buf_sel and buf_valid changes mid-frame ignored
    buf_sel = 2'd3; buf_valid = 1'b1;
    wait_txctl(1'b1, 50, n);
    buf_valid = 1'b0;
    repeat (30) cyc();
    buf_sel = 2'd0; buf_valid = 1'b1;
    repeat (5) cyc();
    buf_valid = 1'b0;
    wait_txctl(1'b0, 200, n);
    chk("rd_hold_slot3", rd_addr, {2'd3, 11'd45});
    buf_valid = 1'b1;
    wait_txctl(1'b1, 100, n);
    buf_valid = 1'b0;
    wait_txctl(1'b0, 200, n);
    chk("rd_hold_slot0", rd_addr, {2'd0, 11'd45});
    repeat (20) cyc();

    // reset at payload byte 10 truncates the frame
    rstn = 1'b0; cyc(); rstn = 1'b1; cyc();
    buf_valid = 1'b1;
    wait_txctl(1'b1, 50, n);
    buf_valid = 1'b0;
    fd0 = fd_count;
    repeat (34) cyc();
    rstn = 1'b0;
    cyc();
    chk("trunc_txctl", txctl, 0);
    chk("trunc_seq", seq, 0);
    rstn = 1'b1;
    repeat (20) cyc();
    chk("trunc_no_done", fd_count, fd0);
    buf_valid = 1'b1;
    wait_txctl(1'b1, 50, n);
    buf_valid = 1'b0;
    wait_txctl(1'b0, 200, n);
    chk("post_trunc_len", n, L);
    repeat (15) cyc();
    chk("post_trunc_seq", seq, 1);

    // randomized requests, slot selects and occasional resets
    repeat (4000) begin
      buf_valid = ($urandom_range(0, 3) != 0);
      buf_sel   = SW'($urandom_range(0, NB - 1));
      rstn      = ($urandom_range(0, 599) != 0);
      cyc();
    end
    rstn = 1'b1; buf_valid = 1'b0;
    repeat (100) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 Parameters: PAYLOAD_LEN, 1024, payload bytes per frame, legal 46..1500.
REQ-002 Parameter: NBUF, 2, number of payload buffer slots, power of two, 2..16; SW = log2(NBUF).
REQ-003 Parameters: DST_MAC, 48'h222222222222; SRC_MAC, 48'h666666666666; ETYPE, 16'h1919; header constants, sent MSB byte first.
REQ-004 Parameter: IFG, 12, idle byte-times between frames, legal 12..255.
REQ-005 Parameter: RD_LAT, 1, buffer read latency in cycles, legal 1..4.
REQ-006 One clock, clk125; reset rstn is synchronous and active-low.
REQ-007 Ports: clk125 in 1 byte clock; rstn in 1 sync active-low reset; buf_valid in 1 frame request; buf_sel in SW slot to send; buf_ready out 1 request accepted when high with buf_valid; rd_addr out SW+11 = {slot, payload offset}; rd_data in 8 payload byte, RD_LAT cycles after rd_addr; txctl out 1 tx enable; txd out 4 DDR nibble; seq out 16 current sequence number; frame_done out 1 single-cycle pulse; busy out 1 frame or IFG in progress.

Function
REQ-008 All state and outputs SHALL update on posedge clk125 only; txd SHALL be the sole combinational output: txd = clk125 ? txbyte[3:0] : txbyte[7:4], txbyte registered.
REQ-009 States: IDLE, PRE, HDR, PAY, FCS, IFG; byte counter 11 bits, one byte per cycle.
REQ-010 IDLE: buf_ready=1; on buf_valid&&buf_ready, latch buf_sel, go PRE; txctl=1 and first byte on txbyte from the next cycle.
REQ-011 PRE: 7 bytes 0x55 then 1 byte 0xD5.
REQ-012 HDR: DST_MAC (6), SRC_MAC (6), ETYPE (2), seq low byte, seq high byte -- 16 bytes.
REQ-013 PAY: PAYLOAD_LEN bytes from rd_data; payload byte j SHALL be the value returned for rd_addr={latched slot, j}; rd_addr issued RD_LAT+1 cycles ahead of use so no bubble appears.
REQ-014 FCS: 4 bytes, LSB first, of ~CRC; CRC reflected poly 0xEDB88320, init 0xFFFFFFFF, LSB-first per byte, over HDR+PAY bytes only.
REQ-015 Frame length on txctl SHALL be exactly 28+PAYLOAD_LEN cycles, contiguous.
REQ-016 IFG: txctl=0, txbyte=0x00 for exactly IFG cycles, buf_ready=0, then IDLE.
REQ-017 buf_valid held high SHALL yield back-to-back frames separated by exactly IFG idle cycles.
REQ-018 buf_valid outside IDLE SHALL be ignored (no queueing); buf_sel changes mid-frame SHALL not affect the frame.
REQ-019 seq SHALL increment by 1 on the last FCS byte of each frame, wrapping 0xFFFF->0x0000; header carries pre-increment value.
REQ-020 frame_done SHALL pulse in the cycle after the last FCS byte (first IFG cycle).
REQ-021 busy=1 in every state except IDLE.
REQ-022 rd_addr SHALL hold its last value when not reading; no read-enable port (reads side-effect free).

Reset
REQ-023 rstn=0 sampled at a posedge SHALL force IDLE, txctl=0, txbyte=0x00, seq=0, frame_done=0, busy=0, buf_ready=0 during reset and 1 on first cycle after release, rd_addr=0, CRC=0xFFFFFFFF.
REQ-024 Reset mid-frame SHALL truncate the frame immediately (txctl=0 next cycle), without FCS and without incrementing seq.

Verification
REQ-025 Reset: rstn=0 for 3 cycles with buf_valid=1 -> txctl=0, txd=0, seq=0, buf_ready=0; release -> buf_ready=1, txctl=1 one cycle after accept.
REQ-026 PAYLOAD_LEN=46, RD_LAT=2, memory byte j = j: 74-byte frame 55x7,D5,22x6,66x6,19,19,00,00,00..2D,FCS; CRC register over bytes 8..73 without final invert equals residue 0xDEBB20E3.
REQ-027 buf_valid held, 3 frames: txctl low exactly 12 cycles between frames, seq fields 0,1,2, three frame_done pulses, seq=3 after.
REQ-028 NBUF=4, buf_sel=3, toggled to 0 mid-frame: every payload rd_addr top bits=3; next frame uses slot 0.
REQ-029 rstn=0 at payload byte 10: txctl=0 next cycle, no frame_done, seq unchanged; next frame header carries same seq.
REQ-030 Run 65536 frames (PAYLOAD_LEN=46): seq header wraps 0xFFFF -> 0x0000, FCS correct on both.
